// File: rtl/md_pkg.sv
// md_pkg: shared types for the MD force-pipeline control blocks.
// Holds the drain tracker state encoding and small helpers.
package md_pkg;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    DRAIN   = 2'd1,
    DONE    = 2'd2
  } drain_state_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ref_wb_popcount.sv
// ref_wb_popcount: counts set bits in a WIDTH-bit vector.
// Purely combinational; result width fits WIDTH itself.
module ref_wb_popcount #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] vec,
  output logic [CNT_W-1:0] cnt
);

  // Accumulate one per set bit.
  always_comb begin
    cnt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt = cnt + CNT_W'(vec[i]);
    end
  end

endmodule

// File: rtl/ref_wb_drain_tracker.sv
// ref_wb_drain_tracker: collects per-PE ref writebacks, then waits for the ring to drain.
// Optional drain watchdog is built only when DRAIN_TIMEOUT_EN is defined.
module ref_wb_drain_tracker
  import md_pkg::*;
#(
  parameter int NUM_CELLS      = 125,
  parameter int MAX_INFLIGHT   = 4 * NUM_CELLS,
  parameter int DRAIN_HOLD     = 2,
  parameter int TIMEOUT_CYCLES = 8 * NUM_CELLS
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_CELLS-1:0]                ref_wb_issued,
  input  logic [NUM_CELLS-1:0]                pkt_inject,
  input  logic [NUM_CELLS-1:0]                pkt_eject,
  input  logic                                goto_next_ref,
  input  logic                                cache_buf_empty,
  input  logic                                filter_buf_empty,
  input  logic                                all_reading_done,
  output logic                                all_ref_wb_issued,
  output logic                                interconnect_empty,
  output logic                                all_force_wr_issued,
  output logic                                motion_update_start,
  output logic [$clog2(MAX_INFLIGHT+1)-1:0]   inflight_count,
  output logic                                count_err,
  output logic                                timeout_err
);

  localparam int CW = $clog2(MAX_INFLIGHT + 1);
  localparam int PW = $clog2(NUM_CELLS + 1);
  localparam int SW = max2(CW, PW) + 2;
  localparam int HW = $clog2(DRAIN_HOLD + 1);

  localparam logic [HW-1:0] HOLD_LAST = HW'(DRAIN_HOLD - 1);
  localparam logic signed [SW-1:0] MAX_S = SW'(MAX_INFLIGHT);

  if (DRAIN_HOLD < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("DRAIN_HOLD and TIMEOUT_CYCLES must be >= 1");
  end

  drain_state_t          state_q, state_d;
  logic [NUM_CELLS-1:0]  flags_q, flags_d;
  logic [HW-1:0]         hold_q, hold_d;
  logic [CW-1:0]         inflight_q, inflight_d;
  logic                  count_err_q, count_err_d;
  logic [PW-1:0]         inj_cnt;
  logic [PW-1:0]         ej_cnt;
  logic signed [SW-1:0]  sum;
  logic                  clamp;
  logic                  inflight_zero;
  logic                  hold_hit;

`ifdef DRAIN_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT_CYCLES - 1);

  logic [WW-1:0] wd_q, wd_d;
  logic          timeout_err_q, timeout_err_d;
  logic          wd_hit;

  assign wd_hit      = (wd_q >= WD_LAST);
  assign timeout_err = timeout_err_q;
`else
  assign timeout_err = 1'b0;
`endif

  ref_wb_popcount #(
    .WIDTH (NUM_CELLS),
    .CNT_W (PW)
  ) u_inj_pop (
    .vec (pkt_inject),
    .cnt (inj_cnt)
  );

  ref_wb_popcount #(
    .WIDTH (NUM_CELLS),
    .CNT_W (PW)
  ) u_ej_pop (
    .vec (pkt_eject),
    .cnt (ej_cnt)
  );

  assign inflight_zero = (inflight_q == '0);
  assign hold_hit      = inflight_zero && (hold_q >= HOLD_LAST);

  // Net ring occupancy with saturation at both ends.
  always_comb begin
    sum = $signed(SW'(inflight_q))
        + $signed(SW'(inj_cnt))
        - $signed(SW'(ej_cnt));
    inflight_d = CW'(sum);
    clamp      = 1'b0;
    if (sum[SW-1]) begin
      inflight_d = '0;
      clamp      = 1'b1;
    end else if (sum > MAX_S) begin
      inflight_d = CW'(MAX_INFLIGHT);
      clamp      = 1'b1;
    end
  end

  // Phase sequencing: collect writebacks, wait for drain, hold done.
  always_comb begin
    state_d     = state_q;
    flags_d     = flags_q;
    hold_d      = hold_q;
    count_err_d = count_err_q | clamp;
`ifdef DRAIN_TIMEOUT_EN
    wd_d          = '0;
    timeout_err_d = timeout_err_q;
`endif
    case (state_q)
      COLLECT: begin
        flags_d = flags_q | ref_wb_issued;
        if (&flags_d) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (goto_next_ref) begin
          state_d = COLLECT;
          flags_d = '0;
          hold_d  = '0;
        end else begin
          hold_d = inflight_zero ? hold_q + HW'(1) : '0;
          if (hold_hit) begin
            state_d = DONE;
`ifdef DRAIN_TIMEOUT_EN
          end else if (wd_hit) begin
            state_d       = DONE;
            timeout_err_d = 1'b1;
          end else begin
            wd_d = wd_q + WW'(1);
`endif
          end
        end
      end
      DONE: begin
        if (goto_next_ref) begin
          state_d = COLLECT;
          flags_d = '0;
          hold_d  = '0;
        end
      end
      default: begin
        state_d = COLLECT;
        flags_d = '0;
        hold_d  = '0;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= COLLECT;
      flags_q     <= '0;
      hold_q      <= '0;
      inflight_q  <= '0;
      count_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      flags_q     <= flags_d;
      hold_q      <= hold_d;
      inflight_q  <= inflight_d;
      count_err_q <= count_err_d;
    end
  end

`ifdef DRAIN_TIMEOUT_EN
  // Watchdog counter and its sticky flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_q          <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      wd_q          <= wd_d;
      timeout_err_q <= timeout_err_d;
    end
  end
`endif

  assign all_ref_wb_issued   = (state_q != COLLECT);
  assign interconnect_empty  = (state_q == DONE);
  assign all_force_wr_issued = ~|pkt_eject
                             & cache_buf_empty
                             & filter_buf_empty
                             & interconnect_empty;
  assign motion_update_start = all_reading_done & all_force_wr_issued;
  assign inflight_count      = inflight_q;
  assign count_err           = count_err_q;

endmodule

// File: tb/tb_ref_wb_drain_tracker.sv
// tb_ref_wb_drain_tracker: directed plus randomized check of the drain tracker.
// A phase/count model in the bench predicts every output each cycle.
module tb_ref_wb_drain_tracker;

  localparam int N    = 4;
  localparam int MAXI = 16;
  localparam int HOLD = 2;
  localparam int TMO  = 16;
  localparam int CW   = $clog2(MAXI + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  wb, inj, ej;
  logic          gnr, cbe, fbe, ard;
  logic          arwi, ice, afwi, mus;
  logic [CW-1:0] cnt;
  logic          cerr, terr;

  int errors = 0;
  int checks = 0;
  bit started = 1'b0;

  // phase: 0 gathering writebacks, 1 waiting for ring, 2 ring drained
  typedef struct {
    int flags;
    int phase;
    int hold;
    int cnt;
    bit cerr;
    bit terr;
    int wd;
  } mdl_t;

  mdl_t m;

  ref_wb_drain_tracker #(
    .NUM_CELLS      (N),
    .MAX_INFLIGHT   (MAXI),
    .DRAIN_HOLD     (HOLD),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .ref_wb_issued       (wb),
    .pkt_inject          (inj),
    .pkt_eject           (ej),
    .goto_next_ref       (gnr),
    .cache_buf_empty     (cbe),
    .filter_buf_empty    (fbe),
    .all_reading_done    (ard),
    .all_ref_wb_issued   (arwi),
    .interconnect_empty  (ice),
    .all_force_wr_issued (afwi),
    .motion_update_start (mus),
    .inflight_count      (cnt),
    .count_err           (cerr),
    .timeout_err         (terr)
  );

  always #5 clk = ~clk;

  function automatic mdl_t mstep(mdl_t s);
    mdl_t r;
    int n;
    r = s;
    if (rst) begin
      r = '{flags: 0, phase: 0, hold: 0, cnt: 0,
            cerr: 1'b0, terr: 1'b0, wd: 0};
      return r;
    end
    n = s.cnt + $countones(inj) - $countones(ej);
    if (n < 0) begin
      n = 0;
      r.cerr = 1'b1;
    end else if (n > MAXI) begin
      n = MAXI;
      r.cerr = 1'b1;
    end
    r.cnt = n;
    if (s.phase == 0) begin
      r.flags = s.flags | int'(wb);
      if (r.flags == (1 << N) - 1) begin
        r.phase = 1;
        r.wd = 0;
      end
    end else if (gnr) begin
      r.phase = 0;
      r.flags = 0;
      r.hold = 0;
    end else if (s.phase == 1) begin
      r.hold = (s.cnt == 0) ? s.hold + 1 : 0;
      r.wd = s.wd + 1;
      if (r.hold >= HOLD) begin
        r.phase = 2;
      end
`ifdef DRAIN_TIMEOUT_EN
      else if (r.wd >= TMO) begin
        r.phase = 2;
        r.terr = 1'b1;
      end
`endif
    end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               nm, got, exp, $time);
    end
  endtask

  // Advance the model alongside the DUT.
  always @(posedge clk) begin
    m <= mstep(m);
    started <= 1'b1;
  end

  // Compare every output against the model each cycle.
  always @(negedge clk) begin
    if (started) begin
      chk("all_ref_wb_issued", 32'(arwi), 32'(m.phase != 0));
      chk("interconnect_empty", 32'(ice), 32'(m.phase == 2));
      chk("all_force_wr_issued", 32'(afwi),
          32'((ej == '0) && cbe && fbe && (m.phase == 2)));
      chk("motion_update_start", 32'(mus),
          32'(ard && (ej == '0) && cbe && fbe && (m.phase == 2)));
      chk("inflight_count", 32'(cnt), 32'(m.cnt));
      chk("count_err", 32'(cerr), 32'(m.cerr));
      chk("timeout_err", 32'(terr), 32'(m.terr));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    wb  = '0;
    inj = '0;
    ej  = '0;
    gnr = 1'b0;
  endtask

  initial begin
    int mode;
    m = '{flags: 0, phase: 0, hold: 0, cnt: 0,
          cerr: 1'b0, terr: 1'b0, wd: 0};
    clr();
    rst = 1'b1;
    cbe = 1'b1;
    fbe = 1'b1;
    ard = 1'b1;
    tick();
    tick();
    chk("rst_arwi", 32'(arwi), 32'd0);
    chk("rst_ice", 32'(ice), 32'd0);
    chk("rst_afwi", 32'(afwi), 32'd0);
    chk("rst_mus", 32'(mus), 32'd0);
    chk("rst_cnt", 32'(cnt), 32'd0);
    chk("rst_cerr", 32'(cerr), 32'd0);
    chk("rst_terr", 32'(terr), 32'd0);
    rst = 1'b0;

    wb = 4'b0111;
    tick();
    wb = 4'b1000;
    tick();
    wb = '0;
    chk("wb_drain_arwi", 32'(arwi), 32'd1);
    chk("wb_drain_ice", 32'(ice), 32'd0);
    tick();
    chk("hold1_ice", 32'(ice), 32'd0);
    tick();
    chk("done_ice", 32'(ice), 32'd1);
    chk("done_afwi", 32'(afwi), 32'd1);
    chk("done_mus", 32'(mus), 32'd1);

    inj = 4'b0001;
    tick();
    inj = '0;
    chk("done_inj_cnt", 32'(cnt), 32'd1);
    ej = 4'b0001;
    #1;
    chk("eject_mus", 32'(mus), 32'd0);
    chk("eject_afwi", 32'(afwi), 32'd0);
    tick();
    ej = '0;
    #1;
    chk("post_eject_mus", 32'(mus), 32'd1);
    chk("post_eject_cnt", 32'(cnt), 32'd0);
    chk("post_eject_cerr", 32'(cerr), 32'd0);

    gnr = 1'b1;
    tick();
    gnr = 1'b0;
    chk("goto_done_arwi", 32'(arwi), 32'd0);

    wb  = 4'b1111;
    inj = 4'b0111;
    tick();
    clr();
    chk("inj3_cnt", 32'(cnt), 32'd3);
    chk("inj3_arwi", 32'(arwi), 32'd1);
    repeat (4) tick();
    chk("inj3_wait_cnt", 32'(cnt), 32'd3);
    chk("inj3_wait_ice", 32'(ice), 32'd0);
    for (int k = 0; k < 3; k++) begin
      ej = 4'b0001;
      tick();
      chk("drain_step_cnt", 32'(cnt), 32'(2 - k));
    end
    ej = '0;
    chk("zero_ice", 32'(ice), 32'd0);
    tick();
    chk("zero_hold_ice", 32'(ice), 32'd0);
    tick();
    chk("zero_done_ice", 32'(ice), 32'd1);

    gnr = 1'b1;
    tick();
    gnr = 1'b0;
    wb  = 4'b1111;
    inj = 4'b0011;
    tick();
    clr();
    chk("pre_goto_arwi", 32'(arwi), 32'd1);
    gnr = 1'b1;
    tick();
    gnr = 1'b0;
    chk("goto_drain_arwi", 32'(arwi), 32'd0);
    chk("goto_drain_cnt", 32'(cnt), 32'd2);
    wb = 4'b0111;
    tick();
    wb = '0;
    tick();
    chk("flags_cleared_arwi", 32'(arwi), 32'd0);
    ej = 4'b0011;
    tick();
    ej = '0;
    chk("cleanup_cnt", 32'(cnt), 32'd0);

    ej = 4'b0001;
    tick();
    ej = '0;
    chk("under_cnt", 32'(cnt), 32'd0);
    chk("under_cerr", 32'(cerr), 32'd1);
    repeat (3) tick();
    chk("under_sticky", 32'(cerr), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("under_rst_cerr", 32'(cerr), 32'd0);

    wb  = 4'b1111;
    inj = 4'b0001;
    tick();
    clr();
    repeat (15) tick();
    chk("wd15_ice", 32'(ice), 32'd0);
    tick();
`ifdef DRAIN_TIMEOUT_EN
    chk("wd16_ice", 32'(ice), 32'd1);
    chk("wd16_terr", 32'(terr), 32'd1);
`else
    chk("wd16_ice", 32'(ice), 32'd0);
    chk("wd16_terr", 32'(terr), 32'd0);
`endif
    rst = 1'b1;
    tick();
    rst = 1'b0;

    inj = 4'b1111;
    repeat (5) tick();
    inj = '0;
    chk("over_cnt", 32'(cnt), 32'd16);
    chk("over_cerr", 32'(cerr), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;

    mode = 0;
    for (int c = 0; c < 3000; c++) begin
      if (c % 48 == 0) mode = $urandom_range(2);
      rst = ($urandom_range(249) == 0);
      gnr = ($urandom_range(11) == 0);
      wb  = N'($urandom) & N'($urandom);
      cbe = ($urandom_range(3) != 0);
      fbe = ($urandom_range(3) != 0);
      ard = ($urandom_range(2) != 0);
      if (mode == 0) begin
        inj = N'($urandom) & N'($urandom);
        ej  = N'($urandom) & N'($urandom) & N'($urandom);
      end else if (mode == 1) begin
        inj = N'($urandom) & N'($urandom) & N'($urandom);
        ej  = N'($urandom) & N'($urandom);
      end else begin
        inj = '0;
        ej  = ($urandom_range(7) == 0) ? N'($urandom) : '0;
      end
      tick();
    end
    clr();
    rst = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
